// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types, frame constant and parity helper for the PS/2
//               host transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } ps2_state_e;

  // Falling edges in one host-to-device frame: 8 data, parity, stop, ack.
  localparam int PS2_FRAME_EDGES = 11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================================
// Module      : ps2_line_sync
// Description : 2-flop synchronizers for the PS/2 clock and data pads plus a
//               falling-edge pulse on the synchronized clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_clk_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;

  // Idle PS/2 lines float high, so every flop resets to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign o_clk_s    = r_clk_sync[1];
  assign o_data_s   = r_data_sync[1];
  assign o_clk_fall = r_clk_prev & ~r_clk_sync[1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter over open-collector
//               clock/data lines. Optional watchdog: PS2_TX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2600,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int c_INH_W = $clog2(INHIBIT_CYCLES + 1);

  ps2_state_e         r_state;
  ps2_state_e         w_state_nxt;
  logic [c_INH_W-1:0] r_inh_cnt;
  logic [9:0]         r_shift;
  logic               r_tx_bit;
  logic [3:0]         r_edge_cnt;
  logic               r_ack_ok;
  logic               r_done;
  logic               r_error;

  logic w_clk_s;
  logic w_data_s;
  logic w_clk_fall;
  logic w_accept;
  logic w_inh_last;
  logic w_timeout;
  logic w_finish;
  logic w_finish_err;

  ps2_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_clk_s   (w_clk_s),
    .o_data_s  (w_data_s),
    .o_clk_fall(w_clk_fall)
  );

  assign ready      = (r_state == S_IDLE);
  assign busy       = ~ready;
  assign done       = r_done;
  assign error      = r_error;
  assign w_accept   = data_valid & ready;
  assign w_inh_last = (r_inh_cnt == c_INH_W'(INHIBIT_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_WD_W-1:0] r_wdog;

  // Held clear until the clock is released, then restarted by each falling edge.
  always_ff @(posedge clk) begin
    if (reset || r_state == S_IDLE || r_state == S_INHIBIT || w_clk_fall) begin
      r_wdog <= '0;
    end else if (!w_timeout) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = (r_wdog == c_WD_W'(TIMEOUT_CYCLES));
`else
  // No watchdog: a silent device parks the block until reset.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_finish     = 1'b0;
    w_finish_err = 1'b0;
    ps2_clk_oe   = 1'b0;
    ps2_data_oe  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (data_valid) w_state_nxt = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = w_inh_last;
        if (w_inh_last) w_state_nxt = S_REQ;
      end
      S_REQ, S_SHIFT: begin
        ps2_data_oe = ~r_tx_bit;
        if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_finish     = 1'b1;
          w_finish_err = 1'b1;
        end else if (w_clk_fall) begin
          if (r_state == S_REQ) begin
            w_state_nxt = S_SHIFT;
          end else if (r_edge_cnt == 4'(PS2_FRAME_EDGES - 2)) begin
            w_state_nxt = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_finish     = 1'b1;
          w_finish_err = 1'b1;
        end else if (w_clk_fall) begin
          w_state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_finish     = 1'b1;
          w_finish_err = 1'b1;
        end else if (w_clk_s && w_data_s) begin
          w_state_nxt  = S_IDLE;
          w_finish     = 1'b1;
          w_finish_err = ~r_ack_ok;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register holds {stop, parity, byte}; r_tx_bit is the bit on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inh_cnt  <= '0;
      r_shift    <= '0;
      r_tx_bit   <= 1'b1;
      r_edge_cnt <= '0;
      r_ack_ok   <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) r_error <= w_finish_err;
      if (w_accept) begin
        r_shift    <= {1'b1, odd_parity(data_in), data_in};
        r_tx_bit   <= 1'b0;
        r_edge_cnt <= '0;
        r_inh_cnt  <= '0;
        r_ack_ok   <= 1'b0;
      end
      if (r_state == S_INHIBIT) r_inh_cnt <= r_inh_cnt + 1'b1;
      if (w_clk_fall && (r_state inside {S_REQ, S_SHIFT, S_ACK})) begin
        if (r_edge_cnt != 4'(PS2_FRAME_EDGES)) r_edge_cnt <= r_edge_cnt + 1'b1;
        r_tx_bit <= r_shift[0];
        r_shift  <= {1'b1, r_shift[9:1]};
        if (r_state == S_ACK) r_ack_ok <= ~w_data_s;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model
//               and a frame/error scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH  = 2600;
  localparam int TMO  = 5000;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready, busy, done, error, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_pad, ps2_data_pad;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  logic [10:0] exp_frame_q[$];
  logic        exp_err_q[$];

  always #5 clk = ~clk;

  assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk    (ps2_clk_pad),
    .ps2_data   (ps2_data_pad),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic send_byte(input logic [7:0] b, input logic exp_err);
    @(negedge clk);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    exp_frame_q.push_back({1'b1, ~^b, b, 1'b0});
    exp_err_q.push_back(exp_err);
  endtask

  // Device model: waits for clock release, then clocks max_edges falling edges,
  // sampling each host bit late in the low phase.
  task automatic dev_frame(input int max_edges, input bit do_ack,
                           output logic [10:0] bits, output bit timed_out);
    int n = 0;
    bits      = '0;
    timed_out = 1'b0;
    while (ps2_clk_oe !== 1'b0 && n < INH + 50) begin
      @(negedge clk);
      n++;
    end
    if (ps2_clk_oe !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    bits[0] = ps2_data_pad;
    for (int e = 1; e <= max_edges; e++) begin
      if (e == 11 && do_ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (e <= 10) bits[e] = ps2_data_pad;
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(output bit got, output logic err);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    got = (done === 1'b1);
    err = error;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, busy, done, error, ps2_clk_oe, ps2_data_oe} !== 6'b100000)
      $display("FAIL reset_outputs: got %b, required 100000",
               {ready, busy, done, error, ps2_clk_oe, ps2_data_oe});
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, busy, done, ps2_clk_oe, ps2_data_oe} !== 5'b10000)
      $display("FAIL idle_after_reset: got %b, required 10000",
               {ready, busy, done, ps2_clk_oe, ps2_data_oe});
    else n_pass++;
  endtask

  task automatic test_normal(input logic [7:0] b, input string tag);
    logic [10:0] bits;
    bit          to, got;
    logic        err;
    send_byte(b, 1'b0);
    dev_frame(11, 1'b1, bits, to);
    wait_done(got, err);
    n_checks++;
    if (to || !got) $display("FAIL %s_done: release_timeout=%0b done=%0b, required 0 and 1", tag, to, got);
    else n_pass++;
    n_checks++;
    if (bits !== exp_frame_q[0]) $display("FAIL %s_frame: got %b, required %b", tag, bits, exp_frame_q[0]);
    else n_pass++;
    n_checks++;
    if (err !== exp_err_q[0]) $display("FAIL %s_error: got %b, required %b", tag, err, exp_err_q[0]);
    else n_pass++;
    void'(exp_frame_q.pop_front());
    void'(exp_err_q.pop_front());
    @(negedge clk);
    n_checks++;
    if ({done, ready, ps2_clk_oe, ps2_data_oe} !== 4'b0100)
      $display("FAIL %s_after_done: got %b, required 0100", tag, {done, ready, ps2_clk_oe, ps2_data_oe});
    else n_pass++;
  endtask

  task automatic test_inhibit_timing();
    logic [10:0] bits;
    bit          to, got;
    logic        err, last_doe;
    int          cnt = 0;
    send_byte(8'h00, 1'b0);
    last_doe = 1'b0;
    while (ps2_clk_oe === 1'b1 && cnt < INH + 100) begin
      last_doe = ps2_data_oe;
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt !== INH) $display("FAIL inhibit_len: got %0d cycles, required %0d", cnt, INH);
    else n_pass++;
    n_checks++;
    if (last_doe !== 1'b1 || ps2_data_oe !== 1'b1)
      $display("FAIL start_bit_before_release: got %b%b, required 11", last_doe, ps2_data_oe);
    else n_pass++;
    dev_frame(11, 1'b1, bits, to);
    wait_done(got, err);
    n_checks++;
    if (bits[9] !== 1'b1) $display("FAIL inhibit_parity: got %b, required 1", bits[9]);
    else n_pass++;
    n_checks++;
    if (!got || bits !== exp_frame_q[0] || err !== exp_err_q[0])
      $display("FAIL inhibit_frame: done=%0b frame=%b err=%b, required 1 %b %b",
               got, bits, err, exp_frame_q[0], exp_err_q[0]);
    else n_pass++;
    void'(exp_frame_q.pop_front());
    void'(exp_err_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_nack();
    logic [10:0] bits;
    bit          to, got;
    logic        err;
    send_byte(8'h01, 1'b1);
    dev_frame(11, 1'b0, bits, to);
    wait_done(got, err);
    n_checks++;
    if (bits[9] !== 1'b0) $display("FAIL nack_parity: got %b, required 0", bits[9]);
    else n_pass++;
    n_checks++;
    if (!got || bits !== exp_frame_q[0]) $display("FAIL nack_frame: done=%0b frame=%b, required 1 %b", got, bits, exp_frame_q[0]);
    else n_pass++;
    n_checks++;
    if (err !== exp_err_q[0]) $display("FAIL nack_error: got %b, required %b", err, exp_err_q[0]);
    else n_pass++;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL nack_oes: got %b, required 00", {ps2_clk_oe, ps2_data_oe});
    else n_pass++;
    void'(exp_frame_q.pop_front());
    void'(exp_err_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_back_to_back_busy();
    logic [10:0] bits;
    bit          to, got;
    logic        err;
    int          dc;
    send_byte(8'hF4, 1'b0);
    dc = done_cnt;
    fork
      dev_frame(11, 1'b1, bits, to);
      begin
        repeat (INH + 300) @(negedge clk);
        data_in    = 8'hAA;
        data_valid = 1'b1;
        n_checks++;
        if (ready !== 1'b0 || busy !== 1'b1) $display("FAIL busy_flag: ready=%b busy=%b, required 0 1", ready, busy);
        else n_pass++;
        repeat (4) @(negedge clk);
        data_valid = 1'b0;
      end
    join
    wait_done(got, err);
    n_checks++;
    if (!got || bits !== exp_frame_q[0] || err !== exp_err_q[0])
      $display("FAIL busy_frame: done=%0b frame=%b err=%b, required 1 %b %b",
               got, bits, err, exp_frame_q[0], exp_err_q[0]);
    else n_pass++;
    void'(exp_frame_q.pop_front());
    void'(exp_err_q.pop_front());
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt !== dc + 1 || ready !== 1'b1 || ps2_clk_oe !== 1'b0)
      $display("FAIL busy_single_done: dones=%0d ready=%b clk_oe=%b, required %0d 1 0",
               done_cnt - dc, ready, ps2_clk_oe, 1);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n = 0;
    int dc;
    send_byte(8'hFF, 1'b1);
    while (ps2_clk_oe !== 1'b0 && n < INH + 50) begin
      @(negedge clk);
      n++;
    end
    dc = done_cnt;
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (done !== 1'b1 && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done !== 1'b1 || n < TMO || n > TMO + 2)
      $display("FAIL timeout_done: done=%b after %0d cycles, required 1 after %0d..%0d", done, n, TMO, TMO + 2);
    else n_pass++;
    n_checks++;
    if (error !== exp_err_q[0] || {ps2_clk_oe, ps2_data_oe} !== 2'b00)
      $display("FAIL timeout_error: err=%b oes=%b, required %b 00", error, {ps2_clk_oe, ps2_data_oe}, exp_err_q[0]);
    else n_pass++;
    void'(exp_frame_q.pop_front());
    void'(exp_err_q.pop_front());
    @(negedge clk);
`else
    repeat (TMO + 500) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || done_cnt !== dc)
      $display("FAIL silent_device_busy: busy=%b dones=%0d, required 1 0", busy, done_cnt - dc);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_frame_q.delete();
    exp_err_q.delete();
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_midframe();
    logic [10:0] bits;
    bit          to;
    int          dc;
    send_byte(8'hED, 1'b0);
    dc = done_cnt;
    dev_frame(5, 1'b0, bits, to);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, ready} !== 3'b001)
      $display("FAIL midframe_reset: oes/ready=%b, required 001", {ps2_clk_oe, ps2_data_oe, ready});
    else n_pass++;
    reset = 1'b0;
    exp_frame_q.delete();
    exp_err_q.delete();
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt !== dc || done !== 1'b0)
      $display("FAIL midframe_no_done: dones=%0d, required 0", done_cnt - dc);
    else n_pass++;
    test_normal(8'hED, "after_reset");
  endtask

  initial begin
    reset        = 1'b1;
    data_in      = 8'h00;
    data_valid   = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset();
    test_normal(8'hED, "normal");
    test_inhibit_timing();
    test_nack();
    test_back_to_back_busy();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "simulation bound exceeded");
  end

endmodule

`default_nettype wire
